mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter_if.sv | 34 +++
 rtl/mul_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bus between requesters, the arbiter and one shared signed multiplier.
interface mul_share_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned R = 4
);
  localparam int unsigned IDW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]   req;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   ack;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [2*N-1:0] resp_product;
  logic           resp_err;
  logic           busy;
  logic           mul_start;
  logic [N-1:0]   mul_multiplicand;
  logic [N-1:0]   mul_multiplier;
  logic [2*N-1:0] mul_product;
  logic           mul_done;

  modport master (
    output req, req_a, req_b, mul_product, mul_done,
    input  ack, resp_valid, resp_id, resp_product, resp_err, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );

  modport slave (
    input  req, req_a, req_b, mul_product, mul_done,
    output ack, resp_valid, resp_id, resp_product, resp_err, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one signed multiplier among R requesters,
// with a per-operation timeout on the multiplier's done signal.
module mul_share_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned R       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  mul_share_arbiter_if.slave io_bus
);
  localparam int unsigned IDW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PW  = 2 * N;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [IDW-1:0] r_id, w_id_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_a, w_a_nxt;
  logic [N-1:0]   r_b, w_b_nxt;
  logic [PW-1:0]  r_prod, w_prod_nxt;
  logic           r_err, w_err_nxt;

  logic [R-1:0]   r_ack;
  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;
  logic [PW-1:0]  r_resp_product;
  logic           r_resp_err;
  logic           r_busy;
  logic           r_mul_start;

  logic           w_found;
  logic [IDW-1:0] w_pick;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= R) s = s - R;
    return IDW'(s);
  endfunction

  // First set request at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int unsigned k = 0; k < R; k++) begin
      if (!w_found && io_bus.req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_prod_nxt  = r_prod;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_pick;
          w_a_nxt     = io_bus.req_a[32'(w_pick)*N +: N];
          w_b_nxt     = io_bus.req_b[32'(w_pick)*N +: N];
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.mul_done) begin
          w_prod_nxt  = io_bus.mul_product;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESPOND;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_prod_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RESPOND: begin
        w_ptr_nxt   = wrap_add(r_id, 1);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_id           <= '0;
      r_cnt          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_prod         <= '0;
      r_err          <= 1'b0;
      r_ack          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_resp_err     <= 1'b0;
      r_busy         <= 1'b0;
      r_mul_start    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_id           <= w_id_nxt;
      r_cnt          <= w_cnt_nxt;
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_prod         <= w_prod_nxt;
      r_err          <= w_err_nxt;
      r_ack          <= (w_state_nxt == S_RESPOND) ? (R'(1) << w_id_nxt) : '0;
      r_resp_valid   <= (w_state_nxt == S_RESPOND);
      r_resp_id      <= (w_state_nxt == S_RESPOND) ? w_id_nxt : '0;
      r_resp_product <= (w_state_nxt == S_RESPOND) ? w_prod_nxt : '0;
      r_resp_err     <= (w_state_nxt == S_RESPOND) ? w_err_nxt : 1'b0;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_mul_start    <= (w_state_nxt == S_ISSUE);
    end
  end

  assign io_bus.ack              = r_ack;
  assign io_bus.resp_valid       = r_resp_valid;
  assign io_bus.resp_id          = r_resp_id;
  assign io_bus.resp_product     = r_resp_product;
  assign io_bus.resp_err         = r_resp_err;
  assign io_bus.busy             = r_busy;
  assign io_bus.mul_start        = r_mul_start;
  assign io_bus.mul_multiplicand = r_a;
  assign io_bus.mul_multiplier   = r_b;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (N=4, R=4, TIMEOUT=64) with a one-cycle multiplier model.
module tb_mul_share_arbiter;
  logic clock;
  logic reset;
  logic mul_en;
  logic inj_done;
  logic m_pend = 1'b0;
  logic [7:0] m_p = 8'h00;
  int start_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  mul_share_arbiter_if #(.N(4), .R(4)) bus ();

  mul_share_arbiter #(.N(4), .R(4), .TIMEOUT(64)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    return 8'(sa * sb);
  endfunction

  // Shared multiplier: done one cycle after it samples start; product is junk when not done.
  always @(posedge clock) begin
    bus.mul_done    <= inj_done;
    bus.mul_product <= 8'hEE;
    if (bus.mul_start) start_cnt <= start_cnt + 1;
    if (bus.mul_start && mul_en) begin
      m_pend <= 1'b1;
      m_p    <= smul(bus.mul_multiplicand, bus.mul_multiplier);
    end else if (m_pend) begin
      bus.mul_done    <= 1'b1;
      bus.mul_product <= m_p;
      m_pend          <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_resp(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.resp_valid && n < max_cyc);
    check("resp_seen", 32'(bus.resp_valid), 1);
  endtask

  task automatic wait_start(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.mul_start && n < max_cyc);
    check("start_seen", 32'(bus.mul_start), 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int q;
    int s0;
    int exp_id [4];
    logic [7:0] exp_p [4];

    reset = 1'b1;
    mul_en = 1'b1;
    inj_done = 1'b0;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clock);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_ack",    32'(bus.ack), 0);
    check("rst_valid",  32'(bus.resp_valid), 0);
    check("rst_id",     32'(bus.resp_id), 0);
    check("rst_prod",   32'(bus.resp_product), 0);
    check("rst_err",    32'(bus.resp_err), 0);
    check("rst_start",  32'(bus.mul_start), 0);
    check("rst_mcand",  32'(bus.mul_multiplicand), 0);
    check("rst_mplier", 32'(bus.mul_multiplier), 0);
    reset = 1'b0;

    // 3 x -2, requester drops req after grant; stray req[3] pulse mid-flight
    set_req(0, 4'h3, 4'hE);
    @(negedge clock);
    check("s1_start", 32'(bus.mul_start), 1);
    check("s1_mcand", 32'(bus.mul_multiplicand), 3);
    check("s1_mplier", 32'(bus.mul_multiplier), 'hE);
    check("s1_busy", 32'(bus.busy), 1);
    bus.req[0] = 1'b0;
    bus.req_a[3:0] = 4'h7;
    set_req(3, 4'h1, 4'h1);
    @(negedge clock);
    bus.req[3] = 1'b0;
    check("s1_start_once", 32'(bus.mul_start), 0);
    check("s1_hold", 32'(bus.mul_multiplicand), 3);
    wait_resp(20, n);
    check("s1_lat", 32'(n), 2);
    check("s1_ack", 32'(bus.ack), 'b0001);
    check("s1_id", 32'(bus.resp_id), 0);
    check("s1_prod", 32'(bus.resp_product), 'hFA);
    check("s1_err", 32'(bus.resp_err), 0);
    check("s1_hold_rsp", 32'(bus.mul_multiplicand), 3);
    @(negedge clock);
    check("s1_idle", 32'(bus.busy), 0);
    check("s1_ackclr", 32'(bus.ack), 0);
    inj_done = 1'b1;
    @(negedge clock);
    inj_done = 1'b0;
    q = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.resp_valid || bus.busy) q++;
    end
    check("s1_quiet", 32'(q), 0);

    // all requesters from reset: service 0..3 with one IDLE gap
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'h2);
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) begin
      wait_resp(20, n);
      check("s2_lat", 32'(n), (k == 0) ? 4 : 5);
      check("s2_id", 32'(bus.resp_id), 32'(k));
      check("s2_ack", 32'(bus.ack), 32'(1) << k);
      check("s2_prod", 32'(bus.resp_product), 32'(2 * (k + 1)));
      check("s2_err", 32'(bus.resp_err), 0);
      bus.req[k] = 1'b0;
    end
    repeat (6) @(negedge clock);
    check("s2_starts", 32'(start_cnt - s0), 4);

    // req[1] and req[3] held: alternate
    pulse_reset();
    set_req(1, 4'h2, 4'h3);
    set_req(3, 4'hF, 4'h4);
    exp_id = '{1, 3, 1, 3};
    exp_p = '{8'h06, 8'hFC, 8'h06, 8'hFC};
    for (int k = 0; k < 4; k++) begin
      wait_resp(20, n);
      check("s3_id", 32'(bus.resp_id), 32'(exp_id[k]));
      check("s3_prod", 32'(bus.resp_product), 32'(exp_p[k]));
    end
    bus.req = '0;
    repeat (3) @(negedge clock);

    // multiplier never answers: timeout
    mul_en = 1'b0;
    set_req(2, 4'h5, 4'h5);
    wait_start(10);
    @(negedge clock);
    wait_resp(100, n);
    check("s4_to_lat", 32'(n), 64);
    check("s4_err", 32'(bus.resp_err), 1);
    check("s4_prod", 32'(bus.resp_product), 0);
    check("s4_id", 32'(bus.resp_id), 2);
    check("s4_ack", 32'(bus.ack), 'b0100);
    bus.req[2] = 1'b0;
    repeat (2) @(negedge clock);

    // reset during WAIT aborts; then -8 x -8
    set_req(1, 4'h7, 4'h7);
    wait_start(10);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus.req[1] = 1'b0;
    @(negedge clock);
    check("s5_ack", 32'(bus.ack), 0);
    check("s5_valid", 32'(bus.resp_valid), 0);
    check("s5_busy", 32'(bus.busy), 0);
    check("s5_start", 32'(bus.mul_start), 0);
    check("s5_mcand", 32'(bus.mul_multiplicand), 0);
    check("s5_mplier", 32'(bus.mul_multiplier), 0);
    check("s5_prod0", 32'(bus.resp_product), 0);
    reset = 1'b0;
    mul_en = 1'b1;
    set_req(2, 4'h8, 4'h8);
    wait_resp(20, n);
    check("s5_lat", 32'(n), 4);
    check("s5_id", 32'(bus.resp_id), 2);
    check("s5_prod", 32'(bus.resp_product), 'h40);
    check("s5_ack", 32'(bus.ack), 'b0100);
    check("s5_err", 32'(bus.resp_err), 0);
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
